// File: rtl/spike_addr_encoder.sv
// Spike address encoder: turns a frame of spike bit-words into an ascending AXI4-Stream
// of spike addresses, with a one-entry lookahead so the final beat can carry tlast.
module spike_addr_encoder #(
    parameter int NUM_INPUTS = 10000,
    parameter int ADDR_WIDTH = 14,
    parameter int WORD_WIDTH = 16,
    parameter int WIDX_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_frame_start,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    input  logic [WORD_WIDTH-1:0] i_word_data,
    input  logic                  i_word_last,
    output logic                  o_spike_tvalid,
    input  logic                  i_spike_tready,
    output logic [ADDR_WIDTH-1:0] o_spike_tdata,
    output logic                  o_spike_tlast,
    output logic                  o_frame_done,
    output logic                  o_frame_empty,
    output logic [ADDR_WIDTH:0]   o_spike_count,
    output logic                  o_overflow_err,
    output logic                  o_busy
);

    localparam int BIT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int BASE_W = WIDX_WIDTH + BIT_W + 1;
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam logic [BASE_W-1:0] NUM_LIM = BASE_W'(NUM_INPUTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WIDX_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [WORD_WIDTH-1:0] mask_q, mask_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  last_seen_q, last_seen_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [CNT_W-1:0]      spike_count_q, spike_count_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_empty_q, frame_empty_d;

    logic                  word_ready;
    logic                  word_accept;
    logic                  handshake;
    logic                  out_free;
    logic [BASE_W-1:0]     accept_base;
    logic                  accept_ovf;
    logic [WORD_WIDTH-1:0] load_mask;
    logic                  cand_valid;
    logic [BIT_W-1:0]      cand_idx;
    logic [ADDR_WIDTH-1:0] cand_addr;

    assign word_ready  = (state_q == SCAN) && (mask_q == '0) && !last_seen_q;
    assign word_accept = word_ready && i_word_valid;
    assign handshake   = out_valid_q && i_spike_tready;
    assign out_free    = !out_valid_q || handshake;

    // Incoming word: bits mapping at or past NUM_INPUTS are dropped; a word whose
    // base is already past the end drops everything and flags overflow.
    always_comb begin
        accept_base = BASE_W'(word_idx_q) * BASE_W'(WORD_WIDTH);
        accept_ovf  = (accept_base >= NUM_LIM);
        load_mask   = i_word_data;
        for (int b = 0; b < WORD_WIDTH; b++) begin
            if ((accept_base + BASE_W'(b)) >= NUM_LIM) begin
                load_mask[b] = 1'b0;
            end
        end
    end

    always_comb begin
        cand_valid = (mask_q != '0);
        cand_idx   = '0;
        for (int b = WORD_WIDTH - 1; b >= 0; b--) begin
            if (mask_q[b]) begin
                cand_idx = BIT_W'(b);
            end
        end
        cand_addr = base_q + ADDR_WIDTH'(cand_idx);
    end

    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        mask_d        = mask_q;
        base_d        = base_q;
        last_seen_d   = last_seen_q;
        hold_valid_d  = hold_valid_q;
        hold_addr_d   = hold_addr_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        spike_count_d = spike_count_q;
        overflow_d    = overflow_q;
        frame_done_d  = 1'b0;
        frame_empty_d = 1'b0;

        if (handshake) begin
            out_valid_d   = 1'b0;
            out_last_d    = 1'b0;
            spike_count_d = spike_count_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_frame_start) begin
                    state_d       = SCAN;
                    word_idx_d    = '0;
                    mask_d        = '0;
                    last_seen_d   = 1'b0;
                    hold_valid_d  = 1'b0;
                    spike_count_d = '0;
                end
            end

            // The held address only advances to the output once a successor exists,
            // so whatever remains in hold at end of frame is known to be the last beat.
            SCAN: begin
                if (word_accept) begin
                    mask_d      = load_mask;
                    base_d      = ADDR_WIDTH'(accept_base);
                    last_seen_d = i_word_last;
                    if (word_idx_q != '1) begin
                        word_idx_d = word_idx_q + WIDX_WIDTH'(1);
                    end
                    if (accept_ovf) begin
                        overflow_d = 1'b1;
                    end
                end else if (cand_valid) begin
                    if (!hold_valid_q || out_free) begin
                        mask_d       = mask_q & (mask_q - WORD_WIDTH'(1));
                        hold_valid_d = 1'b1;
                        hold_addr_d  = cand_addr;
                        if (hold_valid_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = hold_addr_q;
                            out_last_d  = 1'b0;
                        end
                    end
                end else if (last_seen_q) begin
                    state_d = FLUSH;
                end
            end

            // Once everything has drained, a zero beat count means the frame was empty.
            FLUSH: begin
                if (hold_valid_q) begin
                    if (out_free) begin
                        out_valid_d  = 1'b1;
                        out_data_d   = hold_addr_q;
                        out_last_d   = 1'b1;
                        hold_valid_d = 1'b0;
                    end
                end else if (!out_valid_q) begin
                    state_d       = DONE;
                    frame_done_d  = 1'b1;
                    frame_empty_d = (spike_count_q == '0);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            word_idx_q    <= '0;
            mask_q        <= '0;
            base_q        <= '0;
            last_seen_q   <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_addr_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            spike_count_q <= '0;
            overflow_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_empty_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            mask_q        <= mask_d;
            base_q        <= base_d;
            last_seen_q   <= last_seen_d;
            hold_valid_q  <= hold_valid_d;
            hold_addr_q   <= hold_addr_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            spike_count_q <= spike_count_d;
            overflow_q    <= overflow_d;
            frame_done_q  <= frame_done_d;
            frame_empty_q <= frame_empty_d;
        end
    end

    assign o_word_ready   = word_ready;
    assign o_spike_tvalid = out_valid_q;
    assign o_spike_tdata  = out_data_q;
    assign o_spike_tlast  = out_last_q;
    assign o_frame_done   = frame_done_q;
    assign o_frame_empty  = frame_empty_q;
    assign o_spike_count  = spike_count_q;
    assign o_overflow_err = overflow_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spike_addr_encoder.sv
// Self-checking bench for spike_addr_encoder: directed frames plus random frames, with
// the expected beat stream built from the set bits of every word sent.
module tb_spike_addr_encoder;

    localparam int NUM_INPUTS = 10000;
    localparam int ADDR_WIDTH = 14;
    localparam int WORD_WIDTH = 16;
    localparam int WIDX_WIDTH = 10;
    localparam int NUM_WORDS  = (NUM_INPUTS + WORD_WIDTH - 1) / WORD_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  frameStart = 1'b0;
    logic                  wordValid = 1'b0;
    logic [WORD_WIDTH-1:0] wordData = '0;
    logic                  wordLast = 1'b0;
    logic                  spikeTready = 1'b0;
    logic                  wordReady;
    logic                  spikeTvalid;
    logic [ADDR_WIDTH-1:0] spikeTdata;
    logic                  spikeTlast;
    logic                  frameDone;
    logic                  frameEmpty;
    logic [ADDR_WIDTH:0]   spikeCount;
    logic                  overflowErr;
    logic                  busy;

    int  vectorCount = 0;
    int  missCount = 0;
    int  expQ[$];
    logic [WORD_WIDTH-1:0] frameWords[$];
    int  doneCount = 0;
    logic emptyAtDone = 1'b0;
    logic lastWordAccepted = 1'b0;
    logic prevStall = 1'b0;
    logic expOverflow = 1'b0;
    int  readyMode = 0;

    spike_addr_encoder #(
        .NUM_INPUTS(NUM_INPUTS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .WORD_WIDTH(WORD_WIDTH),
        .WIDX_WIDTH(WIDX_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_start (frameStart),
        .i_word_valid  (wordValid),
        .o_word_ready  (wordReady),
        .i_word_data   (wordData),
        .i_word_last   (wordLast),
        .o_spike_tvalid(spikeTvalid),
        .i_spike_tready(spikeTready),
        .o_spike_tdata (spikeTdata),
        .o_spike_tlast (spikeTlast),
        .o_frame_done  (frameDone),
        .o_frame_empty (frameEmpty),
        .o_spike_count (spikeCount),
        .o_overflow_err(overflowErr),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Downstream ready pattern: 0 always high, 1 toggling, 2 random, otherwise held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       spikeTready = 1'b1;
                1:       spikeTready = ~spikeTready;
                2:       spikeTready = 1'($urandom_range(0, 1));
                default: spikeTready = 1'b0;
            endcase
        end
    end

    // Every visible beat must be the head of the expected address list.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prevStall) checkOutput("tvalid_hold", spikeTvalid, 1);
            if (spikeTvalid) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_beat_tvalid", spikeTvalid, 0);
                end else begin
                    checkOutput("beat_addr", spikeTdata, expQ[0]);
                    checkOutput("beat_last", spikeTlast, (expQ.size() == 1));
                    if (expQ.size() == 1) checkOutput("tlast_after_last_word", lastWordAccepted, 1);
                    if (spikeTready) void'(expQ.pop_front());
                end
            end
            if (frameDone) begin
                doneCount++;
                emptyAtDone = frameEmpty;
            end
            prevStall = spikeTvalid && !spikeTready;
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic sendWord(input logic [WORD_WIDTH-1:0] d, input logic lst);
        int waited = 0;
        int gap;
        wordValid = 1'b1;
        wordData  = d;
        wordLast  = lst;
        @(negedge clk);
        while (!wordReady && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!wordReady) checkOutput("word_ready_timeout", wordReady, 1);
        @(posedge clk);
        #1;
        wordValid = 1'b0;
        wordLast  = 1'b0;
        if (lst) lastWordAccepted = 1'b1;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseFrameStart();
        frameStart = 1'b1;
        @(posedge clk);
        #1;
        frameStart = 1'b0;
    endtask

    task automatic applyStimulus(input int mode);
        int n = frameWords.size();
        int waited = 0;
        int expBeats;
        expQ.delete();
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < WORD_WIDTH; b++) begin
                if (frameWords[w][b] && (w * WORD_WIDTH + b) < NUM_INPUTS) expQ.push_back(w * WORD_WIDTH + b);
            end
        end
        expBeats = expQ.size();
        if (n > NUM_WORDS) expOverflow = 1'b1;
        doneCount = 0;
        lastWordAccepted = 1'b0;
        readyMode = mode;
        pulseFrameStart();
        for (int w = 0; w < n; w++) sendWord(frameWords[w], (w == n - 1));
        while (doneCount == 0 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        checkOutput("frame_done_count", doneCount, 1);
        checkOutput("frame_empty", emptyAtDone, (expBeats == 0));
        checkOutput("beats_left", expQ.size(), 0);
        checkOutput("spike_count", spikeCount, expBeats);
        checkOutput("overflow_err", overflowErr, expOverflow);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("word_ready_idle", wordReady, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic resetMidFrame();
        int waited = 0;
        expQ.delete();
        for (int b = 0; b < WORD_WIDTH; b++) expQ.push_back(b);
        doneCount = 0;
        lastWordAccepted = 1'b0;
        readyMode = 3;
        spikeTready = 1'b0;
        pulseFrameStart();
        sendWord(16'hFFFF, 1'b0);
        while (!spikeTvalid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("tvalid_before_reset", spikeTvalid, 1);
        #2;
        rst_n = 1'b0;
        expQ.delete();
        expOverflow = 1'b0;
        #1;
        checkOutput("midreset_tvalid", spikeTvalid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_count", spikeCount, 0);
        checkOutput("midreset_overflow", overflowErr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        readyMode = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("post_reset_word_ready", wordReady, 0);
            checkOutput("post_reset_busy", busy, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomFrame(input int maxWords);
        int n = $urandom_range(1, maxWords);
        int density = $urandom_range(0, 3);
        frameWords.delete();
        for (int w = 0; w < n; w++) begin
            case (density)
                0:       frameWords.push_back(WORD_WIDTH'($urandom) & WORD_WIDTH'($urandom) & WORD_WIDTH'($urandom));
                1:       frameWords.push_back(WORD_WIDTH'($urandom));
                2:       frameWords.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'h0000);
                default: frameWords.push_back(WORD_WIDTH'($urandom) | WORD_WIDTH'($urandom));
            endcase
        end
        applyStimulus($urandom_range(0, 2));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_tvalid", spikeTvalid, 0);
        checkOutput("reset_tlast", spikeTlast, 0);
        checkOutput("reset_tdata", spikeTdata, 0);
        checkOutput("reset_word_ready", wordReady, 0);
        checkOutput("reset_frame_done", frameDone, 0);
        checkOutput("reset_frame_empty", frameEmpty, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overflow", overflowErr, 0);
        checkOutput("reset_count", spikeCount, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        frameWords = '{16'h0005, 16'h8000};
        applyStimulus(0);

        frameWords.delete();
        frameWords.push_back(16'h0001);
        for (int w = 1; w < NUM_WORDS; w++) frameWords.push_back(16'h0000);
        applyStimulus(0);

        frameWords.delete();
        for (int w = 0; w < 20; w++) frameWords.push_back(16'h0000);
        applyStimulus(2);

        frameWords = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
        applyStimulus(1);

        frameWords.delete();
        for (int w = 0; w < NUM_WORDS + 1; w++) frameWords.push_back(16'h0000);
        frameWords[NUM_WORDS - 1] = 16'h8000;
        frameWords[NUM_WORDS] = 16'h0001;
        applyStimulus(2);

        for (int i = 0; i < 8; i++) randomFrame(40);

        resetMidFrame();

        for (int i = 0; i < 3; i++) randomFrame(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
